grant_window: RTL and testbench

Downstream companion to the request/grant arbiter FSM. While the arbiter holds its grant indication, this block opens a transfer window, passes a fixed-length burst of data beats from the granted client to the shared sink through one register stage, and raises `o_done` when the burst has drained. `o_done` drives the arbiter's GRANT→REVOKE transition input. An optional watchdog ends a stalled window early.

---
 rtl/grant_window_pkg.sv | 16 +
 rtl/gw_out_stage.sv | 28 ++
 rtl/grant_window.sv | 117 +++++++++++
 tb/tb_grant_window.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/grant_window_pkg.sv
// Shared state encoding and default parameters for the grant window block.
// Latency: n/a (types and constants only).  Backpressure: n/a.
package grant_window_pkg;

    typedef enum logic [1:0] {
        GW_IDLE   = 2'd0,
        GW_ACTIVE = 2'd1,
        GW_DRAIN  = 2'd2,
        GW_DONE   = 2'd3
    } ty_GW_STATE;

    localparam int GW_DATA_W_DEF         = 8;
    localparam int GW_LEN_W_DEF          = 4;
    localparam int GW_TIMEOUT_CYCLES_DEF = 16;

endpackage

// File: rtl/gw_out_stage.sv
// Single-entry output register between granted client and shared sink.
// Latency: 1 cycle from load to out_vld.  Backpressure: holds beat stable until out_rdy.
// The parent loads only when the register is empty or being drained this cycle.
module gw_out_stage #(
    parameter int DATA_W = 8
) (
    input  logic              core_clk,
    input  logic              arst_n,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_dat,
    input  logic              out_rdy,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_dat
);

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (in_vld) begin
            out_vld <= 1'b1;
            out_dat <= in_dat;
        end else if (out_vld && out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/grant_window.sv
// Transfer window opened by an arbiter grant; moves a fixed-length burst to the sink, raises o_done.
// Latency: 1 cycle per beat.  Backpressure: o_ready follows sink readiness; optional
// watchdog (GRANT_WINDOW_TIMEOUT_EN) ends a stalled window early with sticky o_timeout.
module grant_window
    import grant_window_pkg::*;
#(
    parameter int DATA_W         = GW_DATA_W_DEF,
    parameter int LEN_W          = GW_LEN_W_DEF,
    parameter int TIMEOUT_CYCLES = GW_TIMEOUT_CYCLES_DEF
) (
    input  logic              i_ck,
    input  logic              i_arstn,
    input  logic              i_grant,
    input  logic [LEN_W-1:0]  i_burstLen,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_ready,
    output logic              o_done,
    output logic              o_timeout,
    output logic [LEN_W-1:0]  o_beatCount
);

    ty_GW_STATE       state_q, state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic             accept;
    logic             last_beat;
    logic             wd_expire;
    logic             win_open;

    assign win_open  = (state_q == GW_IDLE) && i_grant;
    assign o_ready   = (state_q == GW_ACTIVE) && (!o_valid || i_ready);
    assign accept    = i_valid && o_ready;
    assign last_beat = accept && ((cnt_q + LEN_W'(1)) == len_q);

    assign o_done      = (state_q == GW_DONE);
    assign o_beatCount = cnt_q;

`ifdef GRANT_WINDOW_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q;
    logic            timeout_q;

    // Completion in the expiry cycle takes precedence over the watchdog.
    assign wd_expire = (state_q == GW_ACTIVE) && i_grant && !last_beat &&
                       (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_ck or negedge i_arstn) begin
        if (!i_arstn) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else if (win_open) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == GW_ACTIVE) wd_q <= wd_q + WD_W'(1);
            if (wd_expire) timeout_q <= 1'b1;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign wd_expire = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_ck or negedge i_arstn) begin
        if (!i_arstn) begin
            state_q <= GW_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (win_open) begin
                len_q <= i_burstLen;
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + LEN_W'(1);
            end
        end
    end

    // Grant loss dominates every other exit so a revoked window never reports done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            GW_IDLE:   if (i_grant) state_d = (i_burstLen == '0) ? GW_DONE : GW_ACTIVE;
            GW_ACTIVE: begin
                if (!i_grant)                     state_d = GW_IDLE;
                else if (last_beat || wd_expire) state_d = GW_DRAIN;
            end
            GW_DRAIN: begin
                if (!i_grant)                state_d = GW_IDLE;
                else if (!o_valid || i_ready) state_d = GW_DONE;
            end
            GW_DONE:   if (!i_grant) state_d = GW_IDLE;
            default:   state_d = GW_IDLE;
        endcase
    end

    gw_out_stage #(
        .DATA_W (DATA_W)
    ) u_out_stage (
        .core_clk (i_ck),
        .arst_n   (i_arstn),
        .in_vld   (accept),
        .in_dat   (i_data),
        .out_rdy  (i_ready),
        .out_vld  (o_valid),
        .out_dat  (o_data)
    );

endmodule

// File: tb/tb_grant_window.sv
// Directed vector table plus hand sequences for stall, grant drop, watchdog and reset.
module tb_grant_window;

    logic       i_ck = 1'b0;
    logic       i_arstn;
    logic       i_grant;
    logic [3:0] i_burstLen;
    logic       i_valid;
    logic [7:0] i_data;
    logic       o_ready;
    logic       o_valid;
    logic [7:0] o_data;
    logic       i_ready;
    logic       o_done;
    logic       o_timeout;
    logic [3:0] o_beatCount;

    int errors = 0;
    int checks = 0;

    grant_window #(
        .DATA_W         (8),
        .LEN_W          (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_ck        (i_ck),
        .i_arstn     (i_arstn),
        .i_grant     (i_grant),
        .i_burstLen  (i_burstLen),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .o_ready     (o_ready),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .i_ready     (i_ready),
        .o_done      (o_done),
        .o_timeout   (o_timeout),
        .o_beatCount (o_beatCount)
    );

    always #5 i_ck = ~i_ck;

    typedef struct {
        logic       grant;
        logic [3:0] len;
        logic       valid;
        logic [7:0] data;
        logic       ready;
        logic       e_rdy;
        logic       e_vld;
        logic [7:0] e_dat;
        logic       e_done;
        logic       e_to;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_ck);
        #1;
    endtask

    task automatic drive(input logic g, input logic [3:0] l, input logic v,
                         input logic [7:0] d, input logic r);
        i_grant    = g;
        i_burstLen = l;
        i_valid    = v;
        i_data     = d;
        i_ready    = r;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_time_limit: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [15:0] act_v, exp_v;
        int          n;

        // columns: grant len valid data ready | rdy vld dat done timeout cnt
        vt[0]  = '{1'b0, 4'd3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0};
        vt[1]  = '{1'b1, 4'd3, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0};
        vt[2]  = '{1'b1, 4'd3, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0};
        vt[3]  = '{1'b1, 4'd3, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 4'd1};
        vt[4]  = '{1'b1, 4'd3, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 4'd2};
        vt[5]  = '{1'b1, 4'd3, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 4'd3};
        vt[6]  = '{1'b1, 4'd3, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd3};
        vt[7]  = '{1'b1, 4'd3, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd3};
        vt[8]  = '{1'b0, 4'd3, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd3};
        vt[9]  = '{1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd3};
        vt[10] = '{1'b1, 4'd0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd3};
        vt[11] = '{1'b1, 4'd0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0};
        vt[12] = '{1'b0, 4'd0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0};
        vt[13] = '{1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0};

        i_arstn = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 8'h00, 1'b0);
        #12 i_arstn = 1'b1;
        tick();

        // Len=3 streaming burst, then a zero-length window
        for (int i = 0; i < 14; i++) begin
            drive(vt[i].grant, vt[i].len, vt[i].valid, vt[i].data, vt[i].ready);
            #1;
            act_v = {o_ready, o_valid, (o_valid ? o_data : 8'h00), o_done, o_timeout, o_beatCount};
            exp_v = {vt[i].e_rdy, vt[i].e_vld, (vt[i].e_vld ? vt[i].e_dat : 8'h00),
                     vt[i].e_done, vt[i].e_to, vt[i].e_cnt};
            chk($sformatf("vec%0d", i), 32'(act_v), 32'(exp_v));
            tick();
        end

        // Len=2 with sink stalled for 5 cycles after the first beat
        drive(1'b1, 4'd2, 1'b1, 8'h5A, 1'b0);
        tick();
        chk("stall_first_rdy", 32'(o_ready), 32'd1);
        tick();
        i_data = 8'h77;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("stall_hold%0d", k), 32'({o_ready, o_valid, o_data}), 32'({1'b0, 1'b1, 8'h5A}));
            tick();
        end
        i_ready = 1'b1;
        #1;
        chk("stall_release_rdy", 32'(o_ready), 32'd1);
        tick();
        i_valid = 1'b0;
        chk("stall_drain", 32'({o_ready, o_valid, o_data, o_done}), 32'({1'b0, 1'b1, 8'h77, 1'b0}));
        tick();
        chk("stall_done", 32'({o_done, o_valid, o_beatCount}), 32'({1'b1, 1'b0, 4'd2}));
        i_grant = 1'b0;
        tick();
        tick();

        // Grant dropped after 1 of 4 beats with the sink stalled
        drive(1'b1, 4'd4, 1'b0, 8'h00, 1'b0);
        tick();
        drive(1'b1, 4'd4, 1'b1, 8'hC3, 1'b0);
        tick();
        drive(1'b0, 4'd4, 1'b1, 8'hD4, 1'b0);
        #1;
        chk("drop_rdy_now", 32'(o_ready), 32'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("drop_hold%0d", k),
                32'({o_ready, o_valid, o_data, o_done, o_beatCount}),
                32'({1'b0, 1'b1, 8'hC3, 1'b0, 4'd1}));
            tick();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        chk("drop_delivered", 32'({o_valid, o_done, o_ready}), 32'd0);
        tick();
        chk("drop_no_done", 32'(o_done), 32'd0);

        // Watchdog: len=4, only 2 beats over 16 ACTIVE cycles
        drive(1'b1, 4'd4, 1'b0, 8'h00, 1'b1);
        tick();
        for (int k = 1; k <= 16; k++) begin
            i_valid = (k <= 2);
            i_data  = 8'hE0 + 8'(k);
            tick();
        end
`ifdef GRANT_WINDOW_TIMEOUT_EN
        chk("wd_fire", 32'({o_timeout, o_done, o_ready}), 32'({1'b1, 1'b0, 1'b0}));
        tick();
        chk("wd_done", 32'({o_done, o_timeout, o_beatCount}), 32'({1'b1, 1'b1, 4'd2}));
        i_grant = 1'b0;
        tick();
        tick();
        chk("wd_sticky", 32'({o_timeout, o_done}), 32'({1'b1, 1'b0}));
`else
        chk("wd_absent", 32'({o_timeout, o_done, o_ready, o_beatCount}),
            32'({1'b0, 1'b0, 1'b1, 4'd2}));
        tick();
        tick();
        chk("wd_absent_wait", 32'({o_timeout, o_done, o_ready}), 32'({1'b0, 1'b0, 1'b1}));
        i_grant = 1'b0;
        tick();
        tick();
`endif

        // Final beat on the 16th ACTIVE cycle: completion beats expiry
        drive(1'b1, 4'd2, 1'b0, 8'h00, 1'b1);
        tick();
        for (int k = 1; k <= 16; k++) begin
            i_valid = (k == 1) || (k == 16);
            i_data  = 8'h90 + 8'(k);
            tick();
        end
        i_valid = 1'b0;
        chk("edge_drain", 32'({o_timeout, o_valid, o_data, o_done}), 32'({1'b0, 1'b1, 8'hA0, 1'b0}));
        tick();
        chk("edge_done", 32'({o_done, o_timeout, o_beatCount}), 32'({1'b1, 1'b0, 4'd2}));
        i_grant = 1'b0;
        tick();
        tick();

        // Asynchronous reset mid-burst, then a fresh len=1 window
        drive(1'b1, 4'd4, 1'b0, 8'h00, 1'b0);
        tick();
        drive(1'b1, 4'd4, 1'b1, 8'h9C, 1'b0);
        tick();
        chk("rst_pre", 32'({o_valid, o_beatCount}), 32'({1'b1, 4'd1}));
        #2 i_arstn = 1'b0;
        #1;
        chk("rst_outputs", 32'({o_ready, o_valid, o_data, o_done, o_timeout, o_beatCount}), 32'd0);
        #2 i_arstn = 1'b1;
        drive(1'b1, 4'd1, 1'b0, 8'h00, 1'b1);
        tick();
        drive(1'b1, 4'd1, 1'b1, 8'h3E, 1'b1);
        n = 0;
        while (!o_done && n < 10) begin
            tick();
            i_valid = 1'b0;
            n++;
        end
        chk("rst_fresh_done", 32'({o_done, o_beatCount, o_timeout}), 32'({1'b1, 4'd1, 1'b0}));
        chk("rst_fresh_latency", 32'(n), 32'd2);
        i_grant = 1'b0;
        tick();
        chk("rst_fresh_idle", 32'(o_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
